// File: rtl/cmp_seq_unit_if.sv
// Request/response bundle for the sequential compare unit: operands and opcode in,
// result word and ALU flags out, each side with its own valid/ready pair.
interface cmp_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Sign;
    logic [2:0]       Op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Z;
    logic             V;
    logic             N;

    modport master (
        output in_valid, A, B, Sign, Op, out_ready,
        input  in_ready, out_valid, S, Z, V, N
    );

    modport slave (
        input  in_valid, A, B, Sign, Op, out_ready,
        output in_ready, out_valid, S, Z, V, N
    );
endinterface

// File: rtl/cmp_seq_unit.sv
// Multi-mode EQ/NE/LT/LE/GT/GE comparator that scans operands MSB-first, CHUNK bits per cycle.
// Build option CMP_EARLY_EXIT_EN: stop scanning at the first unequal chunk (otherwise always NCHUNK cycles).
module cmp_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    cmp_seq_unit_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_width
            $error("cmp_seq_unit: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sign_q;
    logic [2:0]       op_q;
    logic [IDX_W-1:0] idx_q;
    logic             lt_q, gt_q, found_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             z_q, v_q, n_q;

    logic [CHUNK-1:0] a_ck, b_ck;
    logic             ck_lt, ck_gt;
    logic             lt_d, gt_d, found_d, decide_d;
    logic [IDX_W-1:0] idx_d;
    logic             legal_d, res_d;
    logic [WIDTH-1:0] s_d;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'd5;
    endfunction

    function automatic logic cmp_outcome(input logic [2:0] op, input logic lt, input logic gt);
        logic eq;
        eq = ~lt & ~gt;
        case (op)
            3'd0:    return eq;
            3'd1:    return ~eq;
            3'd2:    return lt;
            3'd3:    return lt | eq;
            3'd4:    return gt;
            3'd5:    return gt | eq;
            default: return 1'b0;
        endcase
    endfunction

    // Flipping the sign bit of the top chunk turns a two's-complement compare into an unsigned one.
    always_comb begin
        a_ck = a_q[int'(idx_q)*CHUNK +: CHUNK];
        b_ck = b_q[int'(idx_q)*CHUNK +: CHUNK];
        if (sign_q && idx_q == IDX_TOP) begin
            a_ck[CHUNK-1] = ~a_ck[CHUNK-1];
            b_ck[CHUNK-1] = ~b_ck[CHUNK-1];
        end
        ck_lt   = a_ck < b_ck;
        ck_gt   = a_ck > b_ck;
        lt_d    = found_q ? lt_q : ck_lt;
        gt_d    = found_q ? gt_q : ck_gt;
        found_d = found_q | ck_lt | ck_gt;
`ifdef CMP_EARLY_EXIT_EN
        decide_d = ck_lt | ck_gt | (idx_q == '0);
`else
        decide_d = (idx_q == '0);
`endif
        idx_d   = idx_q - 1'b1;
        legal_d = op_legal(op_q);
        res_d   = legal_d & cmp_outcome(op_q, lt_d, gt_d);
        s_d     = WIDTH'(res_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= IDX_TOP;
            found_q     <= 1'b0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            z_q         <= 1'b1;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        sign_q  <= bus.Sign;
                        op_q    <= bus.Op;
                        idx_q   <= IDX_TOP;
                        found_q <= 1'b0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    lt_q    <= lt_d;
                    gt_q    <= gt_d;
                    found_q <= found_d;
                    if (decide_d) begin
                        s_q         <= s_d;
                        z_q         <= ~res_d;
                        v_q         <= ~legal_d;
                        n_q         <= lt_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = out_valid_q;
    assign bus.S         = s_q;
    assign bus.Z         = z_q;
    assign bus.V         = v_q;
    assign bus.N         = n_q;

endmodule

// File: tb/tb_cmp_seq_unit.sv
// Self-checking bench for cmp_seq_unit: directed corner cases plus randomized ops against a behavioural model.
module tb_cmp_seq_unit;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int MAXLAT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmp_seq_unit_if #(.WIDTH(WIDTH)) bus ();

    cmp_seq_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: full-width compare with native signed/unsigned arithmetic.
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic sgn, input logic [2:0] op,
                                  output logic [WIDTH-1:0] s, output logic z,
                                  output logic v, output logic n);
        logic lt, eq, gt, r;
        lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        eq = (a == b);
        gt = !lt && !eq;
        case (op)
            3'd0: r = eq;
            3'd1: r = !eq;
            3'd2: r = lt;
            3'd3: r = lt || eq;
            3'd4: r = gt;
            3'd5: r = gt || eq;
            default: r = 1'b0;
        endcase
        s = WIDTH'(r);
        z = (s == '0);
        v = (op > 3'd5);
        n = lt;
    endfunction

    function automatic int exp_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x;
        x = a ^ b;
`ifdef CMP_EARLY_EXIT_EN
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (x[i]) return NCHUNK - (i / CHUNK);
        end
`endif
        return NCHUNK;
    endfunction

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sgn, input logic [2:0] op, output int lat,
                         output logic [WIDTH-1:0] s, output logic z, output logic v,
                         output logic n);
        bus.A = a;
        bus.B = b;
        bus.Sign = sgn;
        bus.Op = op;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.out_valid && lat < MAXLAT);
        s = bus.S;
        z = bus.Z;
        v = bus.V;
        n = bus.N;
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.S !== '0) begin n_fail++; $display("FAIL rst_S got %h want 0", bus.S); end
        n_tests++; if (bus.Z !== 1'b1) begin n_fail++; $display("FAIL rst_Z got %b want 1", bus.Z); end
        n_tests++; if (bus.V !== 1'b0 || bus.N !== 1'b0) begin n_fail++; $display("FAIL rst_VN got %b%b want 00", bus.V, bus.N); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_low got %b want 0", bus.in_ready); end
        rst_n = 1'b1;
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_scan();
        bus.A = 32'h5555_AAAA;
        bus.B = 32'h5555_AAAA;
        bus.Sign = 1'b0;
        bus.Op = 3'd0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.S !== '0 || bus.Z !== 1'b1) begin n_fail++; $display("FAIL midrst_SZ got %h/%b want 0/1", bus.S, bus.Z); end
        n_tests++; if (bus.V !== 1'b0 || bus.N !== 1'b0) begin n_fail++; $display("FAIL midrst_VN got %b%b want 00", bus.V, bus.N); end
        rst_n = 1'b1;
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
        repeat (NCHUNK + 2) @(posedge clk);
        #1;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_discard got out_valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_eq();
        int lat; logic [WIDTH-1:0] s; logic z, v, n;
        do_op(32'h1234_5678, 32'h1234_5678, 1'b0, 3'd0, lat, s, z, v, n);
        n_tests++; if (lat !== NCHUNK) begin n_fail++; $display("FAIL eq_lat got %0d want %0d", lat, NCHUNK); end
        n_tests++; if (s !== 32'd1 || z !== 1'b0) begin n_fail++; $display("FAIL eq_SZ got %h/%b want 1/0", s, z); end
        n_tests++; if (v !== 1'b0 || n !== 1'b0) begin n_fail++; $display("FAIL eq_VN got %b%b want 00", v, n); end
        finish_op();
    endtask

    task automatic test_signed_lt();
        int lat; logic [WIDTH-1:0] s; logic z, v, n;
        int want_k;
`ifdef CMP_EARLY_EXIT_EN
        want_k = 1;
`else
        want_k = NCHUNK;
`endif
        do_op(32'hFFFF_FFFF, 32'd1, 1'b1, 3'd2, lat, s, z, v, n);
        n_tests++; if (lat !== want_k) begin n_fail++; $display("FAIL slt_lat got %0d want %0d", lat, want_k); end
        n_tests++; if (s !== 32'd1 || n !== 1'b1 || z !== 1'b0) begin n_fail++; $display("FAIL slt_SNZ got %h/%b/%b want 1/1/0", s, n, z); end
        finish_op();
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 3'd2, lat, s, z, v, n);
        n_tests++; if (lat !== want_k) begin n_fail++; $display("FAIL ult_lat got %0d want %0d", lat, want_k); end
        n_tests++; if (s !== '0 || z !== 1'b1 || n !== 1'b0) begin n_fail++; $display("FAIL ult_SZN got %h/%b/%b want 0/1/0", s, z, n); end
        finish_op();
    endtask

    task automatic test_ge_low_chunk();
        int lat; logic [WIDTH-1:0] s; logic z, v, n;
        do_op(32'h0000_0102, 32'h0000_0101, 1'b0, 3'd5, lat, s, z, v, n);
        n_tests++; if (lat !== NCHUNK) begin n_fail++; $display("FAIL ge_lat got %0d want %0d", lat, NCHUNK); end
        n_tests++; if (s !== 32'd1 || n !== 1'b0 || v !== 1'b0) begin n_fail++; $display("FAIL ge_SNV got %h/%b/%b want 1/0/0", s, n, v); end
        finish_op();
    endtask

    task automatic test_illegal();
        int lat; logic [WIDTH-1:0] s; logic z, v, n;
        do_op(32'd3, 32'd5, 1'b0, 3'd7, lat, s, z, v, n);
        n_tests++; if (s !== '0 || z !== 1'b1) begin n_fail++; $display("FAIL ill_SZ got %h/%b want 0/1", s, z); end
        n_tests++; if (v !== 1'b1 || n !== 1'b1) begin n_fail++; $display("FAIL ill_VN got %b%b want 11", v, n); end
        finish_op();
    endtask

    task automatic test_backpressure();
        int lat; logic [WIDTH-1:0] s; logic z, v, n;
        do_op(32'd5, 32'd9, 1'b0, 3'd2, lat, s, z, v, n);
        n_tests++; if (s !== 32'd1) begin n_fail++; $display("FAIL bp_first_S got %h want 1", s); end
        bus.A = 32'h0000_ABCD;
        bus.B = 32'h0000_ABCD;
        bus.Sign = 1'b0;
        bus.Op = 3'd1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_tests++; if (bus.out_valid !== 1'b1 || bus.S !== 32'd1) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b S=%h want 1/1", i, bus.out_valid, bus.S); end
            n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept got in_ready %b want 0", bus.in_ready); end
        lat = 1;
        while (!bus.out_valid && lat < MAXLAT) begin
            @(posedge clk); #1;
            lat++;
        end
        lat--;
        n_tests++; if (lat !== NCHUNK) begin n_fail++; $display("FAIL bp_second_lat got %0d want %0d", lat, NCHUNK); end
        n_tests++; if (bus.S !== '0 || bus.Z !== 1'b1) begin n_fail++; $display("FAIL bp_second_SZ got %h/%b want 0/1", bus.S, bus.Z); end
        finish_op();
    endtask

    task automatic test_random();
        int lat; logic [WIDTH-1:0] s; logic z, v, n;
        logic [WIDTH-1:0] a, b, es; logic sgn, ez, ev, en; logic [2:0] op;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                2: b = {a[WIDTH-1:CHUNK], CHUNK'($urandom)};
                default: b = $urandom;
            endcase
            sgn = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            do_op(a, b, sgn, op, lat, s, z, v, n);
            model(a, b, sgn, op, es, ez, ev, en);
            n_tests++; if (lat !== exp_lat(a, b)) begin n_fail++; $display("FAIL rnd_lat[%0d] got %0d want %0d", i, lat, exp_lat(a, b)); end
            n_tests++; if (s !== es || z !== ez) begin n_fail++; $display("FAIL rnd_SZ[%0d] a=%h b=%h sg=%b op=%0d got %h/%b want %h/%b", i, a, b, sgn, op, s, z, es, ez); end
            n_tests++; if (v !== ev || n !== en) begin n_fail++; $display("FAIL rnd_VN[%0d] a=%h b=%h sg=%b op=%0d got %b%b want %b%b", i, a, b, sgn, op, v, n, ev, en); end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            n_tests++; if (bus.out_valid !== 1'b1 || bus.S !== es) begin n_fail++; $display("FAIL rnd_hold[%0d] got v=%b S=%h want 1/%h", i, bus.out_valid, bus.S, es); end
            finish_op();
            n_tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_idle[%0d] got rdy=%b v=%b want 1/0", i, bus.in_ready, bus.out_valid); end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A    = '0;
        bus.B    = '0;
        bus.Sign = 1'b0;
        bus.Op   = 3'd0;
        test_reset();
        test_reset_mid_scan();
        test_eq();
        test_signed_lt();
        test_ge_low_chunk();
        test_illegal();
        test_backpressure();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
